// File: rtl/cbd_poly_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cbd_poly_buffer_if
//  Purpose  : Bus bundle between the CBD sampler, the ping-pong polynomial
//             buffer and the downstream NTT stage.
//             slave  modport - seen by cbd_poly_buffer
//             master modport - seen by the sampler/controller/consumer side
//  Signals  : in_coeff_i/in_idx_i/in_valid_i  sampler write stream
//             bank_free_o                     write bank can take a polynomial
//             out_coeff_o/out_idx_o/out_last_o/out_valid_o/out_ready_i
//                                             replay stream (valid/ready)
//             clr_err_i, overflow_o, seq_err_o, range_err_o  sticky errors
//  Revision : 1.0  initial release
// ============================================================================
interface cbd_poly_buffer_if #(
    parameter int COEFF_WIDTH = 13
);
    logic [COEFF_WIDTH-1:0] in_coeff_i;
    logic [7:0]             in_idx_i;
    logic                   in_valid_i;
    logic                   bank_free_o;
    logic [COEFF_WIDTH-1:0] out_coeff_o;
    logic [7:0]             out_idx_o;
    logic                   out_last_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic                   clr_err_i;
    logic                   overflow_o;
    logic                   seq_err_o;
    logic                   range_err_o;

    modport slave (
        input  in_coeff_i, in_idx_i, in_valid_i, out_ready_i, clr_err_i,
        output bank_free_o, out_coeff_o, out_idx_o, out_last_o, out_valid_o,
               overflow_o, seq_err_o, range_err_o
    );

    modport master (
        output in_coeff_i, in_idx_i, in_valid_i, out_ready_i, clr_err_i,
        input  bank_free_o, out_coeff_o, out_idx_o, out_last_o, out_valid_o,
               overflow_o, seq_err_o, range_err_o
    );
endinterface
`default_nettype wire

// File: rtl/cbd_poly_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : cbd_poly_buffer
//  Purpose  : Ping-pong polynomial buffer behind the CBD sampler. Captures the
//             fire-and-forget coefficient stream into one of two banks and
//             replays each completed polynomial in index order over
//             valid/ready while the other bank fills.
//  Ports    : clk          clock
//             rst          asynchronous active-high reset
//             bus (slave)  sampler stream, replay stream, sticky error flags
//  Options  : CBD_BUF_RANGE_CHECK_EN - when defined, accepted coefficients are
//             checked against [0,ETA] U [Q-ETA,Q-1]; otherwise range_err_o = 0.
//  Revision : 1.0  initial release
// ============================================================================
module cbd_poly_buffer #(
    parameter int COEFF_WIDTH = 13,
    parameter int N_COEFFS    = 256,
    parameter int Q           = 3329,
    parameter int ETA         = 2
) (
    input wire logic        clk,
    input wire logic        rst,
    cbd_poly_buffer_if.slave bus
);
    localparam int            AW        = $clog2(N_COEFFS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_COEFFS - 1);
    localparam int            EW        = COEFF_WIDTH + 9;   // {last, idx, coeff}

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_DRAIN  = 2'd2
    } rd_state_t;

    // ---------------- storage ----------------
    logic [COEFF_WIDTH-1:0] mem0 [N_COEFFS];
    logic [COEFF_WIDTH-1:0] mem1 [N_COEFFS];
    logic [COEFF_WIDTH-1:0] rd0, rd1;

    // ---------------- write side ----------------
    logic          wb;
    logic [AW-1:0] wr_cnt;
    logic [1:0]    full, full_nx;
    logic          wr_en, wr_wrap, drop, seq_set;
    logic          overflow, seq_err;

    assign wr_en   = bus.in_valid_i && !full[wb];
    assign drop    = bus.in_valid_i && full[wb];
    assign wr_wrap = wr_en && (wr_cnt == LAST_ADDR);
    assign seq_set = wr_en && (bus.in_idx_i != 8'(wr_cnt));

    // ---------------- read side ----------------
    // ib is the bank being fetched from memory, rb the bank that is released
    // when its last beat leaves the FIFO. They differ only while the next
    // bank is prefetched behind the tail of the current one, which keeps the
    // stream bubble-free across a bank switch.
    rd_state_t     state, state_nx;
    logic          ib, rb;
    logic [AW-1:0] rd_cnt;
    logic          issue, room, hs, release_bank;
    logic          pend, pend_bank, pend_last;
    logic [7:0]    pend_idx;
    logic [EW-1:0] fifo_q [2];
    logic          fifo_wp, fifo_rp;
    logic [1:0]    fifo_cnt, occ;
    logic [EW-1:0] head;
    logic          out_valid;

    assign head         = fifo_q[fifo_rp];
    assign out_valid    = (fifo_cnt != 2'd0);
    assign hs           = out_valid && bus.out_ready_i;
    assign release_bank = hs && head[EW-1];
    // Entries the FIFO will hold next cycle if nothing new is issued; the pop
    // of this cycle is credited so a full-rate stream keeps issuing.
    assign occ          = fifo_cnt + {1'b0, pend} - {1'b0, hs};
    assign room         = (occ < 2'd2);

    always_comb begin
        full_nx = full;
        if (release_bank) full_nx[rb] = 1'b0;
        if (wr_wrap)      full_nx[wb] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb       <= 1'b0;
            wr_cnt   <= '0;
            full     <= 2'b00;
            overflow <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            full <= full_nx;
            if (wr_en) begin
                if (wr_wrap) begin
                    wr_cnt <= '0;
                    wb     <= ~wb;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            // a new error wins over a simultaneous clear
            if (drop)                overflow <= 1'b1;
            else if (bus.clr_err_i)  overflow <= 1'b0;
            if (seq_set)             seq_err  <= 1'b1;
            else if (bus.clr_err_i)  seq_err  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !wb) mem0[wr_cnt] <= bus.in_coeff_i;
        if (issue && !ib) rd0 <= mem0[rd_cnt];
    end

    always_ff @(posedge clk) begin
        if (wr_en && wb)  mem1[wr_cnt] <= bus.in_coeff_i;
        if (issue && ib)  rd1 <= mem1[rd_cnt];
    end

    // ---------------- read FSM ----------------
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            RD_IDLE:   if (full[ib] && room) issue = 1'b1;
            RD_STREAM: if (room)             issue = 1'b1;
            RD_DRAIN: begin
                // ib already points at the other bank here
                if (full[ib] && room)  issue    = 1'b1;
                else if (release_bank) state_nx = RD_IDLE;
            end
            default:                         state_nx = RD_IDLE;
        endcase
        if (issue) state_nx = (rd_cnt == LAST_ADDR) ? RD_DRAIN : RD_STREAM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RD_IDLE;
            ib        <= 1'b0;
            rb        <= 1'b0;
            rd_cnt    <= '0;
            pend      <= 1'b0;
            pend_bank <= 1'b0;
            pend_last <= 1'b0;
            pend_idx  <= 8'd0;
        end else begin
            state <= state_nx;
            pend  <= issue;
            if (issue) begin
                pend_bank <= ib;
                pend_idx  <= 8'(rd_cnt);
                pend_last <= (rd_cnt == LAST_ADDR);
                if (rd_cnt == LAST_ADDR) begin
                    rd_cnt <= '0;
                    ib     <= ~ib;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
            if (release_bank) rb <= ~rb;
        end
    end

    // ---------------- output skid FIFO ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            fifo_wp   <= 1'b0;
            fifo_rp   <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            if (pend) begin
                fifo_q[fifo_wp] <= {pend_last, pend_idx, (pend_bank ? rd1 : rd0)};
                fifo_wp         <= ~fifo_wp;
            end
            if (hs) fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, pend} - {1'b0, hs};
        end
    end

    assign bus.out_valid_o = out_valid;
    assign bus.out_coeff_o = head[COEFF_WIDTH-1:0];
    assign bus.out_idx_o   = head[COEFF_WIDTH+7:COEFF_WIDTH];
    assign bus.out_last_o  = out_valid && head[EW-1];
    assign bus.bank_free_o = !full[wb];
    assign bus.overflow_o  = overflow;
    assign bus.seq_err_o   = seq_err;

    // ---------------- optional range checker ----------------
`ifdef CBD_BUF_RANGE_CHECK_EN
    logic in_range, range_set, range_err;

    assign in_range  = (bus.in_coeff_i <= COEFF_WIDTH'(ETA)) ||
                       ((bus.in_coeff_i >= COEFF_WIDTH'(Q - ETA)) &&
                        (bus.in_coeff_i <= COEFF_WIDTH'(Q - 1)));
    assign range_set = wr_en && !in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                range_err <= 1'b0;
        else if (range_set)     range_err <= 1'b1;
        else if (bus.clr_err_i) range_err <= 1'b0;
    end

    assign bus.range_err_o = range_err;
`else
    logic [31:0] unused_cfg;
    assign unused_cfg      = 32'(Q) ^ 32'(ETA);
    assign bus.range_err_o = 1'b0;
`endif

endmodule
`default_nettype wire
